// File: rtl/io_debounce_regs_pkg.sv
// Shared definitions for the switch-debounce / LED register block.
//
// Holds the register address map seen by the SPI slave, the 2-bit LED mode
// encoding and two small helpers: a counter-width function and the LED
// drive decode that turns a mode plus blink phases into a pin level.
package io_debounce_regs_pkg;

    // Register address map
    localparam logic [15:0] ADDR_IO_STATUS   = 16'h0000;
    localparam logic [15:0] ADDR_IO_EVENT    = 16'h0004;
    localparam logic [15:0] ADDR_IO_LED_CTRL = 16'h0008;
    localparam logic [15:0] ADDR_IO_IRQ_MASK = 16'h000C;

    // LED mode encoding, two bits per LED
    typedef enum logic [1:0] {
        LED_OFF  = 2'b00,
        LED_ON   = 2'b01,
        LED_SLOW = 2'b10,
        LED_FAST = 2'b11
    } led_mode_e;

    // Bits needed to hold the values 0..max_val; never returns less than 1
    // so a degenerate parameter cannot produce a zero-width vector.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Pin level for one LED given its mode and the shared blink phases.
    function automatic logic led_drive(input led_mode_e mode,
                                       input logic slow_phase,
                                       input logic fast_phase);
        logic lvl;
        case (mode)
            LED_OFF:  lvl = 1'b0;
            LED_ON:   lvl = 1'b1;
            LED_SLOW: lvl = slow_phase;
            LED_FAST: lvl = fast_phase;
            default:  lvl = 1'b0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/io_debounce_regs_deb_chan.sv
// One switch channel: 2-flop synchroniser followed by a debounce counter.
//
// Ports:
//   clk_100m  in   system clock
//   rst_syn   in   synchronous active-high reset
//   sw        in   raw asynchronous switch level
//   stable    out  debounced level (registered)
//   change    out  high in the cycle 'stable' is being updated, i.e. it is
//                  asserted combinationally on the same edge that flips
//                  'stable', so the parent can set its event flag on that edge
//
// The counter runs while the synchronised level differs from 'stable'.
// Once it has counted DEB_CYCLES mismatching cycles, the next mismatching
// cycle accepts the new level and clears the count. Any cycle where the
// synchronised level agrees with 'stable' clears the count, so a glitch
// shorter than DEB_CYCLES never gets through.
module deb_chan
    import io_debounce_regs_pkg::*;
#(
    parameter int DEB_CYCLES = 100000
) (
    input  logic clk_100m,
    input  logic rst_syn,
    input  logic sw,
    output logic stable,
    output logic change
);

    localparam int CNT_W = cnt_width(DEB_CYCLES);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;
    logic             accept;

    assign mismatch = (sync_p1 != stable);
    assign accept   = mismatch && (cnt == CNT_W'(DEB_CYCLES));
    assign change   = accept;

    // Synchroniser stages then debounce counter / stable level
    always_ff @(posedge clk_100m) begin
        if (rst_syn) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            stable  <= 1'b0;
        end else begin
            sync_p0 <= sw;
            sync_p1 <= sync_p0;
            if (!mismatch) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync_p1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/io_debounce_regs.sv
// Debounced switch inputs and blinking LED outputs behind a small register
// file written from an SPI slave.
//
// Ports:
//   clk_100m       in   system clock (only clock)
//   rst_syn        in   synchronous active-high reset
//   data_mosi      in   32-bit write data, valid with data_mosi_rdy
//   data_mosi_rdy  in   one-cycle write strobe
//   addr           in   16-bit register address, valid with data_mosi_rdy
//   sw_in          in   N_IN raw asynchronous switch inputs
//   led_out        out  N_LED registered LED drive
//   status_reg     out  debounced switch levels, zero-extended
//   event_reg      out  sticky change flags (write-one-to-clear)
//   led_ctrl_reg   out  2-bit mode per LED, LED i in bits [2i+1:2i]
//   irq_mask_reg   out  interrupt enables, zero-extended
//   irq            out  registered OR of (event & mask)
module io_debounce_regs
    import io_debounce_regs_pkg::*;
#(
    parameter int N_IN       = 8,
    parameter int N_LED      = 8,
    parameter int DEB_CYCLES = 100000,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic              clk_100m,
    input  logic              rst_syn,
    input  logic [31:0]       data_mosi,
    input  logic              data_mosi_rdy,
    input  logic [15:0]       addr,
    input  logic [N_IN-1:0]   sw_in,
    output logic [N_LED-1:0]  led_out,
    output logic [31:0]       status_reg,
    output logic [31:0]       event_reg,
    output logic [31:0]       led_ctrl_reg,
    output logic [31:0]       irq_mask_reg,
    output logic              irq
);

    // One tick per quarter of the slow half period; the fast phase toggles
    // on each tick and the slow phase on every fourth, so both stay aligned.
    localparam int TICK_DIV = BLINK_DIV / 4;
    localparam int PRE_W    = cnt_width(TICK_DIV - 1);

    logic [N_IN-1:0]    stable_vec;
    logic [N_IN-1:0]    change_vec;
    logic [N_IN-1:0]    event_q;
    logic [N_IN-1:0]    mask_q;
    logic [2*N_LED-1:0] led_ctrl_q;

    logic [PRE_W-1:0]   pre_cnt;
    logic               tick;
    logic [1:0]         tick_cnt;
    logic               fast_phase;
    logic               slow_phase;
    logic [N_LED-1:0]   led_next;

    logic               wr_event;
    logic               wr_mask;
    logic               wr_led;
    logic [N_IN-1:0]    event_clr;
    logic               unused_wdata;

    // Per-channel synchroniser and debounce
    for (genvar g = 0; g < N_IN; g++) begin : g_chan
        deb_chan #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb_chan (
            .clk_100m (clk_100m),
            .rst_syn  (rst_syn),
            .sw       (sw_in[g]),
            .stable   (stable_vec[g]),
            .change   (change_vec[g])
        );
    end

    // Write decode; STATUS and any unlisted address fall through untouched
    assign wr_event  = data_mosi_rdy && (addr == ADDR_IO_EVENT);
    assign wr_mask   = data_mosi_rdy && (addr == ADDR_IO_IRQ_MASK);
    assign wr_led    = data_mosi_rdy && (addr == ADDR_IO_LED_CTRL);
    assign event_clr = wr_event ? data_mosi[N_IN-1:0] : '0;

    // Bits of the write bus above the implemented register widths are
    // intentionally ignored.
    assign unused_wdata = ^data_mosi;

    // Register file; a new change is ORed in after the clear so it wins
    always_ff @(posedge clk_100m) begin
        if (rst_syn) begin
            event_q    <= '0;
            mask_q     <= '0;
            led_ctrl_q <= '0;
            irq        <= 1'b0;
        end else begin
            event_q <= (event_q & ~event_clr) | change_vec;
            if (wr_mask) begin
                mask_q <= data_mosi[N_IN-1:0];
            end
            if (wr_led) begin
                led_ctrl_q <= data_mosi[2*N_LED-1:0];
            end
            irq <= |(event_q & mask_q);
        end
    end

    // Blink prescaler and phases
    assign tick = (pre_cnt == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk_100m) begin
        if (rst_syn) begin
            pre_cnt    <= '0;
            tick_cnt   <= 2'd0;
            fast_phase <= 1'b0;
            slow_phase <= 1'b0;
        end else if (tick) begin
            pre_cnt    <= '0;
            tick_cnt   <= tick_cnt + 2'd1;
            fast_phase <= ~fast_phase;
            if (tick_cnt == 2'd3) begin
                slow_phase <= ~slow_phase;
            end
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // LED drive decode and output register
    always_comb begin
        led_next = '0;
        for (int i = 0; i < N_LED; i++) begin
            led_next[i] = led_drive(led_mode_e'(led_ctrl_q[2*i +: 2]),
                                    slow_phase, fast_phase);
        end
    end

    always_ff @(posedge clk_100m) begin
        if (rst_syn) begin
            led_out <= '0;
        end else begin
            led_out <= led_next;
        end
    end

    assign status_reg   = 32'(stable_vec);
    assign event_reg    = 32'(event_q);
    assign led_ctrl_reg = 32'(led_ctrl_q);
    assign irq_mask_reg = 32'(mask_q);

endmodule

// File: tb/tb_io_debounce_regs.sv
// Testbench for io_debounce_regs with N_IN=4, N_LED=4, DEB_CYCLES=4,
// BLINK_DIV=16. A cycle-history model predicts every output each cycle;
// directed sequences add hand-computed literal expectations.
module tb_io_debounce_regs;
    import io_debounce_regs_pkg::*;

    localparam int N_IN  = 4;
    localparam int N_LED = 4;
    localparam int DEB   = 4;
    localparam int BLINK = 16;
    localparam int Q     = BLINK / 4;
    localparam int HMAX  = 4096;

    logic              clk_100m = 1'b0;
    logic              rst_syn;
    logic [31:0]       data_mosi;
    logic              data_mosi_rdy;
    logic [15:0]       addr;
    logic [N_IN-1:0]   sw_in;
    logic [N_LED-1:0]  led_out;
    logic [31:0]       status_reg;
    logic [31:0]       event_reg;
    logic [31:0]       led_ctrl_reg;
    logic [31:0]       irq_mask_reg;
    logic              irq;

    always #5 clk_100m = ~clk_100m;

    io_debounce_regs #(
        .N_IN       (N_IN),
        .N_LED      (N_LED),
        .DEB_CYCLES (DEB),
        .BLINK_DIV  (BLINK)
    ) dut (
        .clk_100m      (clk_100m),
        .rst_syn       (rst_syn),
        .data_mosi     (data_mosi),
        .data_mosi_rdy (data_mosi_rdy),
        .addr          (addr),
        .sw_in         (sw_in),
        .led_out       (led_out),
        .status_reg    (status_reg),
        .event_reg     (event_reg),
        .led_ctrl_reg  (led_ctrl_reg),
        .irq_mask_reg  (irq_mask_reg),
        .irq           (irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_true(input string name, input bit cond);
        checks++;
        if (!cond) begin
            errors++;
            $display("FAIL %s: condition false at %0t", name, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Histories indexed by clock edge number. s2_h[t] is the synchronised
    // level seen after edge t (sw two edges late, forced 0 around reset).
    // A channel flips at edge t when the synchronised level disagreed with
    // the stable level for the last DEB+1 samples and no reset hit the window.
    int               cyc = 0;
    int               age = 0;
    logic [N_IN-1:0]  sw_h [HMAX];
    logic             rst_h[HMAX];
    logic [N_IN-1:0]  s2_h [HMAX];
    logic [N_IN-1:0]  m_stable = '0;
    logic [N_IN-1:0]  m_event  = '0;
    logic [N_IN-1:0]  m_mask   = '0;
    logic [2*N_LED-1:0] m_ctrl = '0;
    logic [N_LED-1:0] m_led    = '0;
    logic             m_irq    = 1'b0;
    bit               m_valid  = 0;

    initial forever begin : mdl
        logic [N_IN-1:0]  chg;
        logic [N_IN-1:0]  clr;
        logic [N_LED-1:0] led_n;
        logic             irq_n;
        logic             prev_rst;
        logic [N_IN-1:0]  prev_sw;
        bit               fast, slow, all_diff;
        int               md;
        @(posedge clk_100m);
        cyc++;
        if (cyc >= HMAX) begin
            $display("FAIL model_history: cycle budget exceeded");
            $fatal(1, "history overflow");
        end
        sw_h[cyc]  = sw_in;
        rst_h[cyc] = rst_syn;
        prev_rst   = (cyc == 1) ? 1'b1 : rst_h[cyc-1];
        prev_sw    = (cyc == 1) ? '0 : sw_h[cyc-1];
        s2_h[cyc]  = (rst_syn || prev_rst) ? '0 : prev_sw;
        if (rst_syn) begin
            age = 0;
            m_stable = '0; m_event = '0; m_mask = '0; m_ctrl = '0;
            m_led = '0; m_irq = 1'b0;
        end else begin
            age++;
            fast = (((age - 1) / Q) % 2) == 1;
            slow = (((age - 1) / (4 * Q)) % 2) == 1;
            for (int i = 0; i < N_LED; i++) begin
                md = int'(m_ctrl[2*i +: 2]);
                led_n[i] = (md == 0) ? 1'b0 : (md == 1) ? 1'b1 : (md == 2) ? slow : fast;
            end
            irq_n = |(m_event & m_mask);
            chg = '0;
            for (int ch = 0; ch < N_IN; ch++) begin
                if (age >= DEB + 1) begin
                    all_diff = 1;
                    for (int k = 1; k <= DEB + 1; k++)
                        if (s2_h[cyc-k][ch] == m_stable[ch]) all_diff = 0;
                    if (all_diff) chg[ch] = 1'b1;
                end
            end
            m_stable = m_stable ^ chg;
            clr = (data_mosi_rdy && addr == ADDR_IO_EVENT) ? data_mosi[N_IN-1:0] : '0;
            m_event = (m_event & ~clr) | chg;
            if (data_mosi_rdy && addr == ADDR_IO_IRQ_MASK) m_mask = data_mosi[N_IN-1:0];
            if (data_mosi_rdy && addr == ADDR_IO_LED_CTRL) m_ctrl = data_mosi[2*N_LED-1:0];
            m_led = led_n;
            m_irq = irq_n;
        end
        m_valid = 1;
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk_100m);
        if (m_valid) begin
            check("model_status",   status_reg,   32'(m_stable));
            check("model_event",    event_reg,    32'(m_event));
            check("model_led_ctrl", led_ctrl_reg, 32'(m_ctrl));
            check("model_irq_mask", irq_mask_reg, 32'(m_mask));
            check("model_irq",      32'(irq),     32'(m_irq));
            check("model_led_out",  32'(led_out), 32'(m_led));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        addr = a;
        data_mosi = d;
        data_mosi_rdy = 1'b1;
        @(negedge clk_100m);
        data_mosi_rdy = 1'b0;
        addr = '0;
        data_mosi = '0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic ev;
        int   n;
        rst_syn = 1'b1;
        sw_in = '0;
        data_mosi = '0;
        data_mosi_rdy = 1'b0;
        addr = '0;
        repeat (3) @(negedge clk_100m);
        check("rst_status", status_reg, 32'h0);
        check("rst_led", 32'(led_out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rst_syn = 1'b0;

        wr(ADDR_IO_IRQ_MASK, 32'h1);
        check("mask_write", irq_mask_reg, 32'h1);

        // clean edge on ch0: accepted on edge 7, irq one edge later
        sw_in[0] = 1'b1;
        repeat (6) @(negedge clk_100m);
        check("edge_c6_status", status_reg, 32'h0);
        @(negedge clk_100m);
        check("edge_c7_status", status_reg, 32'h1);
        check("edge_c7_event", event_reg, 32'h1);
        check("edge_c7_irq", 32'(irq), 32'h0);
        @(negedge clk_100m);
        check("edge_c8_irq", 32'(irq), 32'h1);

        // 3-cycle glitch on ch1 must be rejected
        sw_in[1] = 1'b1;
        repeat (3) @(negedge clk_100m);
        sw_in[1] = 1'b0;
        repeat (10) @(negedge clk_100m);
        check("glitch_status", status_reg, 32'h1);
        check("glitch_event", event_reg, 32'h1);

        // W1C, then a clear coinciding with a new ch2 edge
        sw_in[2] = 1'b1;
        repeat (7) @(negedge clk_100m);
        check("w1c_pre", event_reg, 32'h5);
        wr(ADDR_IO_EVENT, 32'h4);
        check("w1c_clear", event_reg, 32'h1);
        sw_in[2] = 1'b0;
        repeat (6) @(negedge clk_100m);
        wr(ADDR_IO_EVENT, 32'h4);
        check("w1c_set_wins", event_reg, 32'h5);
        check("w1c_status", status_reg, 32'h1);
        wr(ADDR_IO_EVENT, 32'hF);
        check("w1c_all", event_reg, 32'h0);

        // upper bits and ignored addresses
        wr(ADDR_IO_IRQ_MASK, 32'hFFFF_FFFF);
        check("upper_mask", irq_mask_reg, 32'h0000_000F);
        wr(ADDR_IO_STATUS, 32'hFFFF_FFFF);
        check("upper_status", status_reg, 32'h1);
        wr(16'h1234, 32'hFFFF_FFFF);
        check("unlisted_ctrl", led_ctrl_reg, 32'h0);

        // LED modes: 0 off, 1 on, 2 slow, 3 fast
        wr(ADDR_IO_LED_CTRL, 32'hE4);
        check("led_ctrl", led_ctrl_reg, 32'hE4);
        @(negedge clk_100m);
        check("led0_off", 32'(led_out[0]), 32'h0);
        check("led1_on", 32'(led_out[1]), 32'h1);

        ev = led_out[3];
        n = 0;
        while (led_out[3] == ev && n < 8) begin
            @(negedge clk_100m);
            n++;
        end
        check_true("led3_align", n < 8);
        ev = led_out[3];
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk_100m);
            if (i % 4 == 0) ev = ~ev;
            check("led3_fast", 32'(led_out[3]), 32'(ev));
        end

        ev = led_out[2];
        n = 0;
        while (led_out[2] == ev && n < 20) begin
            @(negedge clk_100m);
            n++;
        end
        check_true("led2_align", n < 20);
        ev = led_out[2];
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk_100m);
            if (i % 16 == 0) ev = ~ev;
            check("led2_slow", 32'(led_out[2]), 32'(ev));
        end

        // reset two cycles into a ch3 transition
        sw_in[3] = 1'b1;
        repeat (2) @(negedge clk_100m);
        rst_syn = 1'b1;
        @(negedge clk_100m);
        check("mid_rst_status", status_reg, 32'h0);
        check("mid_rst_event", event_reg, 32'h0);
        check("mid_rst_ctrl", led_ctrl_reg, 32'h0);
        check("mid_rst_mask", irq_mask_reg, 32'h0);
        check("mid_rst_led", 32'(led_out), 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        @(negedge clk_100m);
        rst_syn = 1'b0;
        repeat (6) @(negedge clk_100m);
        check("post_rst_no_early", status_reg, 32'h0);
        @(negedge clk_100m);
        check("post_rst_status", status_reg, 32'h9);
        check("post_rst_event", event_reg, 32'h9);
        wr(ADDR_IO_EVENT, 32'h9);
        check("post_rst_clear", event_reg, 32'h0);

        repeat (2) @(negedge clk_100m);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
